eth_tx_arbiter: RTL and testbench

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

---
 rtl/eth_tx_arb_pkg.sv | 9 +
 rtl/eth_tx_arbiter.sv | 102 ++++++++++
 tb/tb_eth_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arb_pkg.sv
// eth_tx_arb_pkg: shared widths, FSM state type and beat-counter width helper for eth_tx_arbiter
package eth_tx_arb_pkg;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  function automatic int beat_w(input int max_beats);
    return (max_beats > 2) ? $clog2(max_beats) : 1;
  endfunction
endpackage

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: two-source round-robin AXI-Stream packet arbiter toward MAC TX, with jumbo length truncation
//   clock/reset        : single clock, synchronous active-high reset
//   link_up            : gates new grants only; packets in flight always complete
//   s0_axis_*/s1_axis_*: requester streams (tdata/tkeep/tlast/tuser/tvalid in, tready out)
//   m_axis_*           : zero-latency pass-through of the granted requester
//   tx_pkt_count       : packets closed on m_axis (normal + truncated), wrapping
//   tx_abort_count     : packets truncated at MAX_BEATS, saturating
module eth_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int MAX_BEATS = 1200
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              link_up,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic [KEEP_W-1:0] s0_axis_tkeep,
  input  logic              s0_axis_tlast,
  input  logic              s0_axis_tuser,
  input  logic              s0_axis_tvalid,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic [KEEP_W-1:0] s1_axis_tkeep,
  input  logic              s1_axis_tlast,
  input  logic              s1_axis_tuser,
  input  logic              s1_axis_tvalid,
  output logic              s1_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [31:0]       tx_pkt_count,
  output logic [15:0]       tx_abort_count
);
  localparam int BW = beat_w(MAX_BEATS);
  localparam logic [BW-1:0] LAST_IDX = BW'(MAX_BEATS - 1);
  state_t          r_state, w_next;
  logic            r_grant, r_last_grant;
  logic [BW-1:0]   r_beat;
  logic [31:0]     r_pkt;
  logic [15:0]     r_abort;
  logic [DATA_W-1:0] w_src_tdata;
  logic [KEEP_W-1:0] w_src_tkeep;
  logic            w_src_tlast, w_src_tuser, w_src_tvalid;
  logic            w_pass, w_drop, w_grant_rdy, w_xfer, w_src_hs, w_abort, w_go, w_pick;
  assign w_src_tdata  = r_grant ? s1_axis_tdata  : s0_axis_tdata;
  assign w_src_tkeep  = r_grant ? s1_axis_tkeep  : s0_axis_tkeep;
  assign w_src_tlast  = r_grant ? s1_axis_tlast  : s0_axis_tlast;
  assign w_src_tuser  = r_grant ? s1_axis_tuser  : s0_axis_tuser;
  assign w_src_tvalid = r_grant ? s1_axis_tvalid : s0_axis_tvalid;
  // outputs are forced quiet while reset is held, even before the state register clears
  assign w_pass = (r_state == PASS) & ~reset;
  assign w_drop = (r_state == DROP) & ~reset;
  assign w_grant_rdy = w_pass ? m_axis_tready : w_drop;
  assign w_abort = (r_beat == LAST_IDX) & ~w_src_tlast;
  assign w_xfer = m_axis_tvalid & m_axis_tready;
  assign w_src_hs = w_src_tvalid & w_grant_rdy;
  assign w_go = link_up & (s0_axis_tvalid | s1_axis_tvalid);
  // round-robin: on contention the source not granted last time wins
  assign w_pick = (s0_axis_tvalid & s1_axis_tvalid) ? ~r_last_grant : s1_axis_tvalid;
  assign m_axis_tdata   = w_src_tdata;
  assign m_axis_tkeep   = w_src_tkeep;
  assign m_axis_tlast   = w_src_tlast | w_abort;
  assign m_axis_tuser   = w_src_tuser | w_abort;
  assign m_axis_tvalid  = w_pass & w_src_tvalid;
  assign s0_axis_tready = ~r_grant & w_grant_rdy;
  assign s1_axis_tready = r_grant & w_grant_rdy;
  assign tx_pkt_count   = r_pkt;
  assign tx_abort_count = r_abort;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_go ? PASS : IDLE;
      PASS:    w_next = (w_xfer & w_src_tlast) ? IDLE : (w_xfer & w_abort) ? DROP : PASS;
      DROP:    w_next = (w_src_hs & w_src_tlast) ? IDLE : DROP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat       <= '0;
      r_pkt        <= '0;
      r_abort      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_go) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
        r_beat       <= '0;
      end else if (w_xfer) begin
        r_beat <= r_beat + BW'(1);
      end
      if (w_xfer & (w_src_tlast | w_abort)) r_pkt <= r_pkt + 32'd1;
      if (w_xfer & w_abort & ~&r_abort) r_abort <= r_abort + 16'd1;
    end
  end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: packet-level scoreboard bench for eth_tx_arbiter
module tb_eth_tx_arbiter;
  localparam int MAXB = 4;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;
  logic clock = 1'b0, reset = 1'b1, link_up = 1'b1, m_tready = 1'b1;
  logic [63:0] s0_tdata, s1_tdata, m_tdata, b_tdata;
  logic [7:0]  s0_tkeep, s1_tkeep, m_tkeep, b_tkeep;
  logic        s0_tlast, s1_tlast, s0_tuser, s1_tuser, s0_tvalid, s1_tvalid;
  logic        s0_tready, s1_tready, m_tlast, m_tuser, m_tvalid;
  logic        b_tlast, b_tuser, b_tvalid, b_s0_tready, b_s1_tready;
  logic [31:0] tx_pkt_count, b_pkt;
  logic [15:0] tx_abort_count, b_abort;
  int n_tests = 0, n_fail = 0, cyc = 0;
  int idx [2];
  int s_hs_cnt [2];
  int m_xfers, a_vcnt, b_xfers, b_last_at, b_vcnt;
  logic [31:0] mdl_pkt;
  logic [15:0] mdl_abort;
  logic last_m_l, last_m_u, snap_mv, snap_r0, snap_r1, hs0, hs1, rnd = 1'b0;
  int start_cyc[$], start_src[$];
  beat_t q0[$], q1[$];
  always #5 clock = ~clock;
  eth_tx_arbiter #(.MAX_BEATS(MAXB)) dut (
    .clock(clock), .reset(reset), .link_up(link_up),
    .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tlast(s0_tlast),
    .s0_axis_tuser(s0_tuser), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tlast(s1_tlast),
    .s1_axis_tuser(s1_tuser), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .tx_pkt_count(tx_pkt_count), .tx_abort_count(tx_abort_count)
  );
  eth_tx_arbiter dut_b (
    .clock(clock), .reset(reset), .link_up(link_up),
    .s0_axis_tdata(s0_tdata), .s0_axis_tkeep(s0_tkeep), .s0_axis_tlast(s0_tlast),
    .s0_axis_tuser(s0_tuser), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(b_s0_tready),
    .s1_axis_tdata(s1_tdata), .s1_axis_tkeep(s1_tkeep), .s1_axis_tlast(s1_tlast),
    .s1_axis_tuser(s1_tuser), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(b_s1_tready),
    .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tlast(b_tlast),
    .m_axis_tuser(b_tuser), .m_axis_tvalid(b_tvalid), .m_axis_tready(m_tready),
    .tx_pkt_count(b_pkt), .tx_abort_count(b_abort)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  task automatic drive();
    beat_t z;
    z = '0;
    {s0_tdata, s0_tkeep, s0_tlast, s0_tuser} = (q0.size() > 0) ? q0[0] : z;
    {s1_tdata, s1_tkeep, s1_tlast, s1_tuser} = (q1.size() > 0) ? q1[0] : z;
    s0_tvalid = q0.size() > 0;
    s1_tvalid = q1.size() > 0;
  endtask
  task automatic add_pkt(input int i, input int len, input logic rand_data, input logic user);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = rand_data ? {$urandom, $urandom} : 64'h1000_0000_0000_0000 * (i + 1) + 64'(k);
      b.k = (rand_data && k == len - 1) ? 8'($urandom) : 8'hFF;
      b.l = (k == len - 1);
      b.u = user;
      if (i == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask
  // expected behaviour of one consumed source beat: first MAXB beats of a packet pass, the
  // MAXB-th closes a too-long packet as an error, later beats are swallowed
  task automatic model_beat(input int i);
    beat_t e;
    int ix;
    e = (i == 0) ? q0[0] : q1[0];
    ix = idx[i];
    if (ix < MAXB) begin
      if (ix == 0) begin
        start_cyc.push_back(cyc);
        start_src.push_back(i);
      end
      chk("m_valid", m_tvalid, 1);
      chk("m_data", m_tdata, e.d);
      chk("m_keep", m_tkeep, e.k);
      chk("m_last", m_tlast, e.l | (ix == MAXB - 1));
      chk("m_user", m_tuser, e.u | (ix == MAXB - 1 && !e.l));
      m_xfers++;
      last_m_l = m_tlast;
      last_m_u = m_tuser;
      if (e.l || ix == MAXB - 1) mdl_pkt++;
      if (!e.l && ix == MAXB - 1 && mdl_abort != 16'hFFFF) mdl_abort++;
    end else begin
      chk("drop_no_valid", m_tvalid, 0);
    end
    s_hs_cnt[i]++;
    idx[i] = e.l ? 0 : ix + 1;
  endtask
  task automatic step();
    @(negedge clock);
    cyc++;
    hs0 = s0_tvalid & s0_tready;
    hs1 = s1_tvalid & s1_tready;
    snap_mv = m_tvalid;
    snap_r0 = s0_tready;
    snap_r1 = s1_tready;
    if (m_tvalid) a_vcnt++;
    if (reset) begin
      chk("rst_outputs", {m_tvalid, s0_tready, s1_tready, b_tvalid}, 0);
    end else begin
      chk("pkt_cnt", tx_pkt_count, mdl_pkt);
      chk("abort_cnt", tx_abort_count, mdl_abort);
      chk("tready_excl", s0_tready & s1_tready, 0);
      if (m_tvalid) chk("tready_eq_mready", s0_tready | s1_tready, m_tready);
      if (m_tvalid & m_tready) chk("xfer_src", hs0 | hs1, 1);
      if (hs0) model_beat(0);
      if (hs1) model_beat(1);
      if (b_tvalid) b_vcnt++;
      if (b_tvalid & m_tready) begin
        b_xfers++;
        if (b_tlast) b_last_at = b_xfers;
      end
    end
    @(posedge clock);
    #1;
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
    m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    drive();
  endtask
  task automatic clear_model();
    q0.delete();
    q1.delete();
    idx[0] = 0;
    idx[1] = 0;
    mdl_pkt = 0;
    mdl_abort = 0;
    drive();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    step();
    step();
    reset = 1'b0;
  endtask
  task automatic clear_tally();
    m_xfers = 0; a_vcnt = 0; b_xfers = 0; b_last_at = 0; b_vcnt = 0;
    s_hs_cnt[0] = 0;
    s_hs_cnt[1] = 0;
    start_cyc.delete();
    start_src.delete();
  endtask
  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while ((q0.size() + q1.size()) > 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", (q0.size() + q1.size()) == 0, 1);
    step();
    step();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t0, total;
    clear_tally();
    @(posedge clock);
    #1;
    do_reset();
    chk("reset_pkt", tx_pkt_count, 0);
    chk("reset_abort", tx_abort_count, 0);
    // round-robin with one idle cycle between packets
    add_pkt(0, 3, 0, 0);
    add_pkt(1, 3, 0, 0);
    add_pkt(0, 3, 0, 0);
    drive();
    clear_tally();
    t0 = cyc;
    step();
    chk("t1_idle_first", snap_mv, 0);
    run_until_done(200);
    chk("t1_npkts", start_src.size(), 3);
    chk("t1_src_a", start_src[0], 0);
    chk("t1_src_b", start_src[1], 1);
    chk("t1_src_c", start_src[2], 0);
    chk("t1_grant_lat", start_cyc[0] - t0, 2);
    chk("t1_gap_ab", start_cyc[1] - start_cyc[0], 4);
    chk("t1_gap_bc", start_cyc[2] - start_cyc[1], 4);
    chk("t1_pkt", tx_pkt_count, 3);
    chk("t1_beats", m_xfers, 9);
    // truncation of an over-long packet
    do_reset();
    clear_tally();
    add_pkt(0, 6, 0, 0);
    drive();
    run_until_done(200);
    chk("t2_m_beats", m_xfers, 4);
    chk("t2_valid_cycles", a_vcnt, 4);
    chk("t2_src_consumed", s_hs_cnt[0], 6);
    chk("t2_beat4_last", last_m_l, 1);
    chk("t2_beat4_user", last_m_u, 1);
    chk("t2_abort", tx_abort_count, 1);
    chk("t2_pkt", tx_pkt_count, 1);
    // link down blocks grants
    do_reset();
    clear_tally();
    link_up = 1'b0;
    add_pkt(1, 2, 0, 1);
    drive();
    repeat (10) step();
    chk("t3_no_valid", a_vcnt, 0);
    chk("t3_no_consume", s_hs_cnt[1], 0);
    link_up = 1'b1;
    step();
    chk("t3_link_cycle1", snap_mv, 0);
    step();
    chk("t3_link_cycle2", snap_mv, 1);
    run_until_done(200);
    chk("t3_pkt", tx_pkt_count, 1);
    // link drop mid-packet on the full-length instance
    do_reset();
    clear_tally();
    add_pkt(0, 5, 0, 0);
    drive();
    step();
    step();
    link_up = 1'b0;
    add_pkt(1, 2, 0, 0);
    drive();
    repeat (14) step();
    chk("t4_b_beats", b_xfers, 5);
    chk("t4_b_last_at", b_last_at, 5);
    chk("t4_b_valid_cycles", b_vcnt, 5);
    chk("t4_s1_blocked", s_hs_cnt[1], 0);
    link_up = 1'b1;
    run_until_done(200);
    chk("t4_b_after_link", b_xfers, 7);
    chk("t4_b_pkt", b_pkt, 2);
    // reset in the middle of a packet
    clear_tally();
    add_pkt(0, 6, 0, 0);
    drive();
    step();
    step();
    step();
    reset = 1'b1;
    clear_model();
    step();
    reset = 1'b0;
    chk("t5_pkt_zero", tx_pkt_count, 0);
    chk("t5_abort_zero", tx_abort_count, 0);
    start_cyc.delete();
    start_src.delete();
    add_pkt(1, 2, 0, 0);
    add_pkt(0, 2, 0, 0);
    drive();
    step();
    chk("t5_post_quiet", {snap_mv, snap_r0, snap_r1}, 0);
    run_until_done(200);
    chk("t5_first_src", start_src[0], 0);
    chk("t5_second_src", start_src[1], 1);
    // random backpressure, 100 packets per source
    do_reset();
    clear_tally();
    total = 0;
    for (int p = 0; p < 100; p++) begin
      for (int i = 0; i < 2; i++) begin
        int len;
        len = $urandom_range(1, 6);
        total += len;
        add_pkt(i, len, 1, 1'($urandom_range(0, 3) == 0));
      end
    end
    rnd = 1'b1;
    drive();
    run_until_done(20000);
    rnd = 1'b0;
    chk("t6_all_consumed", s_hs_cnt[0] + s_hs_cnt[1], total);
    chk("t6_pkt", tx_pkt_count, 200);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
